// File: rtl/sprite_blitter.sv
// sprite_blitter: XOR sprite blitter for a 64x32 1bpp framebuffer (8 bytes per row).
// Commands: NOP, CLEAR (zero all 256 bytes), DRAW (fetch up to 15 sprite rows
// from memory and XOR them into the framebuffer, flagging pixel collisions).
// Build option: define SPRITE_BLITTER_CLIP_EN to discard pixels beyond the
// right/bottom screen edges instead of wrapping them around.
//
// state   | meaning
// IDLE    | ready, waiting for a command strobe
// CLEAR   | writing 0x00 to framebuffer bytes 0..255
// FETCH   | requesting sprite row from memory, waiting for ack
// RD_L    | presenting left framebuffer byte address
// WR_L    | writing left byte (old XOR sprite>>s)
// RD_R    | presenting right framebuffer byte address
// WR_R    | writing right byte (old XOR sprite<<(8-s))
// DONE    | one-cycle completion, back to IDLE
module sprite_blitter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  gpu_cmd,
  input  logic [15:0] gpu_draw_offset,
  input  logic [7:0]  gpu_draw_x,
  input  logic [7:0]  gpu_draw_y,
  input  logic [7:0]  gpu_draw_length,
  input  logic        gpu_cmd_submitted,
  output logic        gpu_ready,
  output logic        gpu_collision,
  output logic        mem_read,
  output logic [11:0] mem_read_addr,
  input  logic [7:0]  mem_read_data,
  input  logic        mem_read_ack,
  output logic [7:0]  fb_addr,
  input  logic [7:0]  fb_rd_data,
  output logic        fb_wr,
  output logic [7:0]  fb_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_RD_L, S_WR_L, S_RD_R, S_WR_R, S_DONE
  } state_t;

  state_t      state;
  logic [11:0] offset_q;
  logic [5:0]  x0_q;
  logic [4:0]  y0_q;
  logic [3:0]  nrows_q;
  logic [3:0]  row_q;
  logic [7:0]  sprite_q;

  logic [15:0] pat_w;
  logic [7:0]  pat_cur;
  logic [3:0]  row_nx;
  logic [4:0]  yr;
  logic [2:0]  col_l;
  logic [2:0]  col_r;
  logic        skip_r;
  logic        row_last;
  logic [3:0]  len_clamp;
  logic        unused_bits;

  // Sprite byte split across two framebuffer bytes: upper half goes left, lower half right.
  assign pat_w     = {sprite_q, 8'h00} >> x0_q[2:0];
  assign pat_cur   = (state == S_WR_R) ? pat_w[7:0] : pat_w[15:8];
  assign row_nx    = row_q + 4'd1;
  assign yr        = y0_q + {1'b0, row_q};
  assign col_l     = x0_q[5:3];
  assign col_r     = col_l + 3'd1;
  assign len_clamp = (gpu_draw_length > 8'd15) ? 4'd15 : gpu_draw_length[3:0];
  assign unused_bits = ^{gpu_draw_offset[15:12], gpu_draw_x[7:6], gpu_draw_y[7:5]};

`ifdef SPRITE_BLITTER_CLIP_EN
  logic [5:0] y_nx_ext;
  assign y_nx_ext = {1'b0, y0_q} + {2'b00, row_nx};
  assign skip_r   = (x0_q[2:0] == 3'd0) || (col_l == 3'd7);
  assign row_last = (row_nx == nrows_q) || y_nx_ext[5];
`else
  assign skip_r   = (x0_q[2:0] == 3'd0);
  assign row_last = (row_nx == nrows_q);
`endif

  // Write strobe and data decode straight from state; read data arrives during WR_x.
  assign fb_wr      = (state == S_CLEAR) || (state == S_WR_L) || (state == S_WR_R);
  assign fb_wr_data = ((state == S_WR_L) || (state == S_WR_R)) ? (fb_rd_data ^ pat_cur) : 8'h00;

  // Command sequencer with registered handshake, memory and address outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      gpu_ready     <= 1'b1;
      gpu_collision <= 1'b0;
      mem_read      <= 1'b0;
      mem_read_addr <= 12'h000;
      fb_addr       <= 8'h00;
      offset_q      <= 12'h000;
      x0_q          <= 6'd0;
      y0_q          <= 5'd0;
      nrows_q       <= 4'd0;
      row_q         <= 4'd0;
      sprite_q      <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (gpu_cmd_submitted) begin
            gpu_ready <= 1'b0;
            case (gpu_cmd)
              4'd1: begin
                fb_addr <= 8'h00;
                state   <= S_CLEAR;
              end
              4'd2: begin
                offset_q      <= gpu_draw_offset[11:0];
                x0_q          <= gpu_draw_x[5:0];
                y0_q          <= gpu_draw_y[4:0];
                nrows_q       <= len_clamp;
                row_q         <= 4'd0;
                gpu_collision <= 1'b0;
                mem_read      <= 1'b0;
                mem_read_addr <= gpu_draw_offset[11:0];
                state         <= (len_clamp == 4'd0) ? S_DONE : S_FETCH;
              end
              default: state <= S_DONE;
            endcase
          end
        end
        S_CLEAR: begin
          fb_addr <= fb_addr + 8'd1;
          if (fb_addr == 8'hFF) begin
            gpu_collision <= 1'b0;
            state         <= S_DONE;
          end
        end
        S_FETCH: begin
          // First entry raises the request; later rows arrive with it already raised.
          if (!mem_read) begin
            mem_read <= 1'b1;
          end else if (mem_read_ack) begin
            sprite_q <= mem_read_data;
            mem_read <= 1'b0;
            fb_addr  <= {yr, col_l};
            state    <= S_RD_L;
          end
        end
        S_RD_L: state <= S_WR_L;
        S_RD_R: state <= S_WR_R;
        S_WR_L, S_WR_R: begin
          if ((fb_rd_data & pat_cur) != 8'h00) gpu_collision <= 1'b1;
          if ((state == S_WR_L) && !skip_r) begin
            fb_addr <= {yr, col_r};
            state   <= S_RD_R;
          end else begin
            row_q <= row_nx;
            if (row_last) begin
              state <= S_DONE;
            end else begin
              mem_read      <= 1'b1;
              mem_read_addr <= offset_q + {8'h00, row_nx};
              state         <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          gpu_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed bench for sprite_blitter with framebuffer and memory models.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  gpu_cmd = 4'd0;
  logic [15:0] gpu_draw_offset = 16'h0000;
  logic [7:0]  gpu_draw_x = 8'd0;
  logic [7:0]  gpu_draw_y = 8'd0;
  logic [7:0]  gpu_draw_length = 8'd0;
  logic        gpu_cmd_submitted = 1'b0;
  logic        gpu_ready;
  logic        gpu_collision;
  logic        mem_read;
  logic [11:0] mem_read_addr;
  logic [7:0]  mem_read_data = 8'h00;
  logic        mem_read_ack = 1'b0;
  logic [7:0]  fb_addr;
  logic [7:0]  fb_rd_data;
  logic        fb_wr;
  logic [7:0]  fb_wr_data;

  int checks = 0;
  int errors = 0;

  sprite_blitter dut (
    .clk(clk), .rst_n(rst_n),
    .gpu_cmd(gpu_cmd), .gpu_draw_offset(gpu_draw_offset),
    .gpu_draw_x(gpu_draw_x), .gpu_draw_y(gpu_draw_y),
    .gpu_draw_length(gpu_draw_length), .gpu_cmd_submitted(gpu_cmd_submitted),
    .gpu_ready(gpu_ready), .gpu_collision(gpu_collision),
    .mem_read(mem_read), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data), .mem_read_ack(mem_read_ack),
    .fb_addr(fb_addr), .fb_rd_data(fb_rd_data),
    .fb_wr(fb_wr), .fb_wr_data(fb_wr_data)
  );

  always #5 clk = ~clk;

  // Framebuffer model: registered read, write on strobe, write log.
  logic [7:0] fb [0:255];
  logic [7:0] wlog_a [0:1023];
  logic [7:0] wlog_d [0:1023];
  logic [9:0] wptr = 10'd0;
  int         wr_total = 0;
  logic       preload = 1'b1;

  always @(posedge clk) begin
    fb_rd_data <= fb[fb_addr];
    if (preload) begin
      for (int i = 0; i < 256; i++) fb[i] <= 8'(i) ^ 8'hA5;
    end else if (fb_wr) begin
      fb[fb_addr]  <= fb_wr_data;
      wlog_a[wptr] <= fb_addr;
      wlog_d[wptr] <= fb_wr_data;
      wptr         <= wptr + 10'd1;
      wr_total     <= wr_total + 1;
    end
  end

  // Sprite memory model with programmable acknowledge delay.
  logic [7:0]  mem [0:4095];
  int          ack_delay = 1;
  int          mr_cnt = 0;
  int          mr_hold = 0;
  logic [11:0] last_rd_addr = 12'h000;

  always @(negedge clk) begin
    if (mem_read) begin
      mr_cnt = mr_cnt + 1;
      if (mr_cnt >= ack_delay) begin
        mem_read_ack  = 1'b1;
        mem_read_data = mem[mem_read_addr];
        mr_hold       = mr_cnt;
        last_rd_addr  = mem_read_addr;
      end else begin
        mem_read_ack = 1'b0;
      end
    end else begin
      mem_read_ack = 1'b0;
      mr_cnt       = 0;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command, scramble inputs afterwards, count cycles with gpu_ready low.
  task automatic run_cmd(input logic [3:0] c, input logic [15:0] off, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] len, input int pulse_at,
                         output int busy);
    @(negedge clk);
    gpu_cmd = c; gpu_draw_offset = off; gpu_draw_x = x; gpu_draw_y = y;
    gpu_draw_length = len; gpu_cmd_submitted = 1'b1;
    @(negedge clk);
    gpu_cmd_submitted = 1'b0;
    gpu_cmd = 4'd0; gpu_draw_offset = 16'hFFFF; gpu_draw_x = 8'hFF;
    gpu_draw_y = 8'hFF; gpu_draw_length = 8'hFF;
    busy = 0;
    while (!gpu_ready && busy < 2000) begin
      busy++;
      gpu_cmd_submitted = (busy == pulse_at);
      if (busy == pulse_at) gpu_cmd = 4'd1;
      @(negedge clk);
    end
    gpu_cmd_submitted = 1'b0;
    gpu_cmd = 4'd0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   busy;
    int   w0;
    logic [9:0] wp0;
    int   bad;

    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[12'h050] = 8'hF0;
    mem[12'h300] = 8'hFF;
    mem[12'h301] = 8'h81;
    mem[12'h100] = 8'hA5;
    mem[12'h200] = 8'h3C;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready",  int'(gpu_ready), 1);
    check("rst_coll",   int'(gpu_collision), 0);
    check("rst_mrd",    int'(mem_read), 0);
    check("rst_maddr",  int'(mem_read_addr), 0);
    check("rst_fbaddr", int'(fb_addr), 0);
    check("rst_fbwr",   int'(fb_wr), 0);
    check("rst_fbwd",   int'(fb_wr_data), 0);
    preload = 1'b0;
    rst_n   = 1'b1;

    // CLEAR over garbage framebuffer
    w0 = wr_total; wp0 = wptr;
    run_cmd(4'd1, 16'h0, 8'd0, 8'd0, 8'd0, -1, busy);
    check("clr_busy", busy, 257);
    check("clr_nwr", wr_total - w0, 256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (wlog_a[wp0 + 10'(i)] != 8'(i) || wlog_d[wp0 + 10'(i)] != 8'h00) bad++;
      if (fb[i] != 8'h00) bad++;
    end
    check("clr_order_data", bad, 0);
    check("clr_coll", int'(gpu_collision), 0);

    // DRAW x=0 y=0 len=1 offset 0x050
    run_cmd(4'd2, 16'h0050, 8'd0, 8'd0, 8'd1, -1, busy);
    check("d1_busy", busy, 5);
    check("d1_raddr", int'(last_rd_addr), 'h050);
    check("d1_hold", mr_hold, 1);
    check("d1_fb0", int'(fb[0]), 'hF0);
    check("d1_coll", int'(gpu_collision), 0);

    // Same DRAW again: XOR back to zero, collision
    run_cmd(4'd2, 16'h0050, 8'd0, 8'd0, 8'd1, -1, busy);
    check("d2_fb0", int'(fb[0]), 0);
    check("d2_coll", int'(gpu_collision), 1);

    // Unknown code acts as NOP, collision untouched
    run_cmd(4'd9, 16'h0, 8'd0, 8'd0, 8'd0, -1, busy);
    check("nop_busy", busy, 1);
    check("nop_coll", int'(gpu_collision), 1);

    // Zero-length DRAW: straight to DONE, clears collision, no writes
    w0 = wr_total;
    run_cmd(4'd2, 16'h0050, 8'd0, 8'd0, 8'd0, -1, busy);
    check("len0_busy", busy, 1);
    check("len0_nwr", wr_total - w0, 0);
    check("len0_coll", int'(gpu_collision), 0);

    // Edge DRAW x=60 y=31 len=2
    w0 = wr_total; wp0 = wptr;
    run_cmd(4'd2, 16'h0300, 8'd60, 8'd31, 8'd2, -1, busy);
`ifdef SPRITE_BLITTER_CLIP_EN
    check("edge_busy", busy, 5);
    check("edge_nwr", wr_total - w0, 1);
    check("edge_w0", int'({wlog_a[wp0], wlog_d[wp0]}), 'hFF0F);
    check("edge_fb248", int'(fb[248]), 0);
    check("edge_fb7", int'(fb[7]), 0);
`else
    check("edge_busy", busy, 12);
    check("edge_nwr", wr_total - w0, 4);
    check("edge_w0", int'({wlog_a[wp0],         wlog_d[wp0]}),         'hFF0F);
    check("edge_w1", int'({wlog_a[wp0 + 10'd1], wlog_d[wp0 + 10'd1]}), 'hF8F0);
    check("edge_w2", int'({wlog_a[wp0 + 10'd2], wlog_d[wp0 + 10'd2]}), 'h0708);
    check("edge_w3", int'({wlog_a[wp0 + 10'd3], wlog_d[wp0 + 10'd3]}), 'h0010);
`endif
    check("edge_coll", int'(gpu_collision), 0);

    // Slow acknowledge with an ignored command pulse while busy
    ack_delay = 4;
    w0 = wr_total;
    run_cmd(4'd2, 16'h0100, 8'd3, 8'd2, 8'd1, 2, busy);
    ack_delay = 1;
    check("slow_busy", busy, 10);
    check("slow_hold", mr_hold, 4);
    check("slow_nwr", wr_total - w0, 2);
    check("slow_fb16", int'(fb[16]), 'h14);
    check("slow_fb17", int'(fb[17]), 'hA0);
    check("slow_coll", int'(gpu_collision), 0);
    check("slow_ready", int'(gpu_ready), 1);

    // Length clamp to 15 rows, origin wraps (x=72 -> 8, y=32 -> 0)
    w0 = wr_total;
    run_cmd(4'd2, 16'h0400, 8'd72, 8'd32, 8'd20, -1, busy);
    check("clamp_busy", busy, 47);
    check("clamp_nwr", wr_total - w0, 15);
    check("clamp_raddr", int'(last_rd_addr), 'h40E);

    // Reset during second row of a 3-row DRAW
    w0 = wr_total;
    @(negedge clk);
    gpu_cmd = 4'd2; gpu_draw_offset = 16'h0200; gpu_draw_x = 8'd0;
    gpu_draw_y = 8'd5; gpu_draw_length = 8'd3; gpu_cmd_submitted = 1'b1;
    @(negedge clk);
    gpu_cmd_submitted = 1'b0; gpu_cmd = 4'd0;
    for (int i = 0; i < 50 && wr_total == w0; i++) @(negedge clk);
    for (int i = 0; i < 50 && !mem_read; i++) @(negedge clk);
    check("abort_row0_nwr", wr_total - w0, 1);
    check("abort_in_fetch", int'(mem_read), 1);
    rst_n = 1'b0;
    #1;
    check("abort_ready", int'(gpu_ready), 1);
    check("abort_mrd", int'(mem_read), 0);
    check("abort_fbwr", int'(fb_wr), 0);
    check("abort_fbaddr", int'(fb_addr), 0);
    @(negedge clk);
    @(negedge clk);
    check("abort_fb40", int'(fb[40]), 'h3C);
    check("abort_nwr", wr_total - w0, 1);
    rst_n = 1'b1;
    run_cmd(4'd0, 16'h0, 8'd0, 8'd0, 8'd0, -1, busy);
    check("post_rst_nop", busy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- gpu_cmd, input, 4: command code; 0=NOP, 1=CLEAR, 2=DRAW, others are treated as NOP.
- gpu_draw_offset, input, 16: sprite base address in memory.
- gpu_draw_x / gpu_draw_y, input, 8 each: sprite origin.
- gpu_draw_length, input, 8: sprite rows.
- gpu_cmd_submitted, input, 1: command strobe.
- gpu_ready, output, 1: idle and able to accept a command.
- gpu_collision, output, 1: result of the last DRAW.
- mem_read, output, 1: memory read request.
- mem_read_addr, output, 12: memory read address.
- mem_read_data, input, 8: memory read data.
- mem_read_ack, input, 1: memory read acknowledge.
- fb_addr, output, 8: framebuffer byte address, equal to row*8 + byte column; the framebuffer is 64x32 pixels, MSB = leftmost pixel.
- fb_rd_data, input, 8: framebuffer read data, valid the cycle after fb_addr is presented.
- fb_wr, output, 1: framebuffer write strobe.
- fb_wr_data, output, 8: framebuffer write data.

Function
REQ-002 SHALL accept a command only in a cycle where gpu_cmd_submitted=1 and gpu_ready=1; gpu_ready SHALL be 0 from the following cycle until the command completes.
REQ-003 SHALL ignore gpu_cmd_submitted while busy, and SHALL register all command inputs at acceptance.
REQ-004 SHALL implement the states IDLE, CLEAR, FETCH, RD_L, WR_L, RD_R, WR_R and DONE; DONE SHALL last one cycle, then return to IDLE with gpu_ready=1.
REQ-005 SHALL complete a NOP by going through DONE only, so gpu_ready is low for exactly 1 cycle; a NOP SHALL leave gpu_collision unchanged.
REQ-006 CLEAR SHALL write 0x00 to addresses 0..255, one write per cycle, in ascending order, for 256 cycles, and SHALL then clear gpu_collision.
REQ-007 DRAW SHALL clear gpu_collision at acceptance and clamp the row count to min(gpu_draw_length,15); a row count of 0 SHALL go straight to DONE with no memory or framebuffer access.
REQ-008 SHALL use x0=gpu_draw_x mod 64 and y0=gpu_draw_y mod 32 as the sprite origin.
REQ-009 For sprite row r, FETCH SHALL hold mem_read=1 and mem_read_addr=(gpu_draw_offset+r)[11:0] until the cycle in which mem_read_ack=1, and SHALL capture mem_read_data in that cycle.
REQ-010 mem_read SHALL deassert in the cycle after the acknowledge.
REQ-011 For screen row yr=(y0+r) mod 32, with shift s=x0[2:0] and column c=x0[5:3], the block SHALL perform the following read-modify-write sequence.
- RD_L presents fb_addr = yr*8+c.
- WR_L writes fb_rd_data XOR (sprite>>s).
- If s≠0, RD_R and WR_R do the same at column (c+1) mod 8 with (sprite<<(8-s))[7:0].
- If s=0, RD_R and WR_R are skipped.
REQ-012 gpu_collision SHALL be set if any written byte satisfies (old AND pattern)≠0, and SHALL be sticky until the next DRAW or CLEAR.
REQ-013 When the row count is reached, the block SHALL go to DONE; otherwise it SHALL go back to FETCH.
REQ-014 With a 1-cycle memory acknowledge, the busy time SHALL be 1 + n*(3 or 5) + 1 cycles, where 3 applies when s=0 and 5 when s≠0.
REQ-015 fb_wr SHALL be high only in WR_L, WR_R and CLEAR, for one cycle per write.
REQ-016 An acknowledge that arrives outside FETCH SHALL be ignored.

Reset
REQ-017 While rst_n=0, the outputs SHALL be gpu_ready=1, gpu_collision=0, mem_read=0, mem_read_addr=0, fb_addr=0, fb_wr=0, fb_wr_data=0, and the state SHALL be IDLE.
REQ-018 Reset asserted mid-operation SHALL abort immediately, and any framebuffer writes already made SHALL remain.
REQ-019 Reset SHALL be released synchronously into IDLE, with the first command accepted no earlier than the first clk edge after deassertion.

Configuration
REQ-020 SHALL honour the macro SPRITE_BLITTER_CLIP_EN.
- Undefined: pixels past x=63 wrap to column 0, and rows past y=31 wrap to row 0.
- Defined: pixels past the right edge are discarded; RD_R/WR_R are skipped when c=7; the draw ends early at the first row with y0+r>31.
- Defined: the origin still wraps as in REQ-008.

Verification
REQ-021 CLEAR after reset -> 256 writes of 0x00 to addresses 0..255, gpu_ready low for 257 cycles, gpu_collision=0.
REQ-022 DRAW x=0, y=0, len=1, offset=0x050, memory[0x050]=0xF0, framebuffer clear, 1-cycle acknowledge -> mem_read_addr=0x050, framebuffer address 0 becomes 0xF0, gpu_collision=0, busy for 5 cycles.
REQ-023 The same DRAW issued twice -> address 0 returns to 0x00 and gpu_collision=1 after the second DRAW.
REQ-024 DRAW x=60, y=31, len=2, sprite bytes 0xFF,0x81 -> without the macro, writes go to addr 255 (0x0F), addr 248 (0xF0), addr 7 (0x08) and addr 0 (0x10); with SPRITE_BLITTER_CLIP_EN, only addr 255=0x0F is written.
REQ-025 gpu_cmd_submitted pulsed during a DRAW with a 4-cycle acknowledge delay -> the pulse is ignored, mem_read is held for 4 cycles, and the draw result is unchanged.
REQ-026 rst_n asserted during the second row of a 3-row DRAW -> gpu_ready=1, mem_read=0, fb_wr=0 immediately, and the first row's writes persist.
